// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the slot SPI master arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ARB,
        SETUP,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

    localparam int DEF_N_REQ     = 2;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_LEN_W     = 5;
    localparam int DEF_DIV_W     = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_START_TMO = 8;

    // Phase counter covers both the setup hold (<=15) and the start timeout (<=255).
    localparam int CNT_W = 8;

    // Index width for a vector of 'value' entries; never below 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether to act on the pick.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate so bit 0 is the pointer position; lowest set offset wins, then unrotate.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW + 1)'(i);
            end
        end
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        idx = sum[IW-1:0];
        if (found) gnt = N'(1) << idx;
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master engine between N_REQ requesters.
// Latency: req_ready one cycle after ARB pick, m_start SETUP_CYC+1 after req_ready, rsp >= 3 after start.
// Backpressure: no grant while engine is not idle+writable; requesters wait with req_valid held.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int START_TMO = DEF_START_TMO,
    parameter int ID_W      = clog2(N_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    input  logic [N_REQ*DIV_W-1:0]    req_div,
    input  logic [N_REQ-1:0]          req_cs,
    input  logic [N_REQ-1:0]          req_cpol,
    input  logic [N_REQ-1:0]          req_cpha,
    input  logic [N_REQ-1:0]          req_lsb,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         m_data,
    output logic [LEN_W-1:0]          m_len,
    output logic [DIV_W-1:0]          m_div,
    output logic                      m_cs,
    output logic                      m_cpol,
    output logic                      m_cpha,
    output logic                      m_lsb,
    output logic                      m_start,
    input  logic                      m_writable,
    input  logic                      m_idle,
    input  logic [DATA_W-1:0]         m_rx,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_idx;
    logic [N_REQ-1:0]  win_gnt;
    logic              win_found;
    logic              eng_ready;
    logic              grant_fire;
    logic              tmo_hit;

    logic [DATA_W-1:0] data_a [N_REQ];
    logic [LEN_W-1:0]  len_a  [N_REQ];
    logic [DIV_W-1:0]  div_a  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
        assign len_a[g]  = req_len[g*LEN_W +: LEN_W];
        assign div_a[g]  = req_div[g*DIV_W +: DIV_W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .found (win_found)
    );

    assign eng_ready  = m_idle & m_writable;
    assign grant_fire = (state == ARB) & win_found & eng_ready;
    // Idle never dropped within the allowed window after the start pulse.
    assign tmo_hit    = (state == WAIT_BUSY) & m_idle & (cnt == CNT_W'(START_TMO - 1));

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ARB;
        else         state <= state_nxt;
    end

    // Next-state: setup hold, start pulse, then track engine idle low/high.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:       if (grant_fire) state_nxt = SETUP;
            SETUP:     if (cnt == CNT_W'(SETUP_CYC)) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!m_idle)      state_nxt = WAIT_DONE;
                else if (tmo_hit) state_nxt = RESP;
            end
            WAIT_DONE: if (m_idle) state_nxt = RESP;
            RESP:      state_nxt = ARB;
            default:   state_nxt = ARB;
        endcase
    end

    // Phase counter restarts on every state change; only SETUP and WAIT_BUSY look at it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                 cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else                         cnt <= cnt + CNT_W'(1);
    end

    // Capture the winner's configuration and advance the RR pointer past it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_data   <= '0;
            m_len    <= '0;
            m_div    <= '0;
            m_cs     <= 1'b0;
            m_cpol   <= 1'b0;
            m_cpha   <= 1'b0;
            m_lsb    <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (grant_fire) begin
            m_data   <= data_a[win_idx];
            m_len    <= len_a[win_idx];
            m_div    <= div_a[win_idx];
            m_cs     <= req_cs[win_idx];
            m_cpol   <= req_cpol[win_idx];
            m_cpha   <= req_cpha[win_idx];
            m_lsb    <= req_lsb[win_idx];
            grant_id <= win_idx;
            rr_ptr   <= (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
        end
    end

    // Registered single-cycle strobes and the busy flag, all derived from the next state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            req_ready <= '0;
            m_start   <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= '0;
        end else begin
            req_ready <= grant_fire ? win_gnt : '0;
            m_start   <= (state_nxt == START);
            busy      <= (state_nxt != ARB);
            rsp_valid <= (state_nxt == RESP) ? (N_REQ'(1) << grant_id) : '0;
        end
    end

    // Response payload: RX word on completion, zero with error on start timeout.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_err <= tmo_hit;
            if (tmo_hit)                               rsp_data <= '0;
            else if ((state == WAIT_DONE) && m_idle)   rsp_data <= m_rx;
        end
    end

endmodule
